// File: rtl/uart_tx_rv32.sv
// -----------------------------------------------------------------------------
// uart_tx_rv32
//   Buffered UART transmitter for the top-level serial pin. Bytes arrive from
//   the core-side bus over a valid/ready handshake. They are queued in a small
//   FIFO and then serialised LSB first at CLK_DIV clocks per bit.
//
// Parameters
//   CLK_DIV     clock cycles per UART bit (>= 2)
//   FIFO_DEPTH  byte FIFO entries (power of 2, >= 2)
//   LVL_W       width of oLEVEL, $clog2(FIFO_DEPTH)+1
//
// Ports
//   iCLK    in   1      system clock, rising edge
//   iRST    in   1      asynchronous active-high reset
//   iDATA   in   8      byte to transmit
//   iVALID  in   1      iDATA valid this cycle
//   oREADY  out  1      FIFO can accept a byte this cycle
//   oTX     out  1      serial line, idle high, driven from a flop
//   oBUSY   out  1      frame on the line or FIFO non-empty
//   oLEVEL  out  LVL_W  bytes currently held in the FIFO
//
// Build option
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted between
//                      the data bits and the stop bit (8E1). When undefined,
//                      the frame is 8N1.
// -----------------------------------------------------------------------------
module uart_tx_rv32 #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [7:0]       iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic             oTX,
  output logic             oBUSY,
  output logic [LVL_W-1:0] oLEVEL
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [7:0]        fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shiftReg_q, shiftReg_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       push;
  logic       pop;
  logic       baudLast;
  logic [7:0] fifoHead;

  assign oREADY   = (count_q != LVL_FULL);
  assign push     = iVALID && oREADY;
  assign baudLast = (baudCnt_q == BAUD_LAST);
  assign fifoHead = fifoMem_q[rdPtr_q];

  assign oTX    = tx_q;
  assign oLEVEL = count_q;
  assign oBUSY  = (state_q != IDLE) || (count_q != '0);

  // FIFO storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= iDATA;
    end
  end

  // Next-state logic for the frame sequencer. A pop happens either from IDLE
  // or on the final cycle of a stop bit, so queued frames run back to back.
  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shiftReg_d = fifoHead;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^fifoHead;
`endif
          bitIdx_d   = 3'd0;
          baudCnt_d  = '0;
          state_d    = START;
        end
      end

      START: begin
        if (baudLast) begin
          baudCnt_d = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baudLast) begin
          baudCnt_d  = '0;
          shiftReg_d = {1'b0, shiftReg_q[7:1]};
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudLast) begin
          baudCnt_d = '0;
          state_d   = STOP;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
`endif

      STOP: begin
        if (baudLast) begin
          baudCnt_d = '0;
          if (count_q != '0) begin
            pop        = 1'b1;
            shiftReg_d = fifoHead;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifoHead;
`endif
            bitIdx_d   = 3'd0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is decoded from the next state so that oTX comes straight from a flop.
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shiftReg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wrPtr_d = push ? (wrPtr_q + PTR_W'(1)) : wrPtr_q;
    rdPtr_d = pop  ? (rdPtr_q + PTR_W'(1)) : rdPtr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // All sequencer and FIFO control state; reset forces the line high at once and empties the FIFO.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      baudCnt_q  <= '0;
      bitIdx_q   <= 3'd0;
      shiftReg_q <= 8'h00;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_rv32.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_rv32
//   Directed bench for uart_tx_rv32 with CLK_DIV=4 and FIFO_DEPTH=4. Each
//   scenario task drives its own stimulus and compares the serial line and
//   status outputs against hand-derived frame bit sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_rv32;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic             iCLK;
  logic             iRST;
  logic [7:0]       iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             oTX;
  logic             oBUSY;
  logic [LVL_W-1:0] oLEVEL;

  int total;
  int bad;

  uart_tx_rv32 #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LVL_W     (LVL_W)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iDATA (iDATA),
    .iVALID(iVALID),
    .oREADY(oREADY),
    .oTX   (oTX),
    .oBUSY (oBUSY),
    .oLEVEL(oLEVEL)
  );

  // Free-running 10 ns clock.
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Expected line level for bit slot idx of a frame carrying byte b:
  // slot 0 start, slots 1..8 data LSB first, optional even parity, then stop.
  function automatic logic expBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Reset state, held through reset and for 20 idle cycles afterwards.
  task automatic test_reset();
    iRST   = 1'b1;
    iVALID = 1'b0;
    iDATA  = 8'h00;
    repeat (3) @(posedge iCLK);
    #1;
    total++;
    if (oTX !== 1'b1 || oBUSY !== 1'b0 || oLEVEL !== 3'd0 || oREADY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_hold: tx=%b busy=%b level=%0d ready=%b expected tx=1 busy=0 level=0 ready=1",
               oTX, oBUSY, oLEVEL, oREADY);
    end
    iRST = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge iCLK);
      #1;
      total++;
      if (oTX !== 1'b1 || oBUSY !== 1'b0 || oLEVEL !== 3'd0 || oREADY !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: tx=%b busy=%b level=%0d ready=%b expected tx=1 busy=0 level=0 ready=1",
                 c, oTX, oBUSY, oLEVEL, oREADY);
      end
    end
  endtask

  // One byte 0x55: line alternates 0,1,0,1... per bit, busy clears after the frame.
  task automatic test_single_frame();
    logic exp;
    iDATA  = 8'h55;
    iVALID = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    total++;
    if (oTX !== 1'b1 || oBUSY !== 1'b1 || oLEVEL !== 3'd1) begin
      bad++;
      $display("[TB] FAIL single_push: tx=%b busy=%b level=%0d expected tx=1 busy=1 level=1", oTX, oBUSY, oLEVEL);
    end
    for (int j = 0; j < FRAME_CYC; j++) begin
      @(posedge iCLK);
      #1;
      exp = expBit(8'h55, j / CLK_DIV);
      total++;
      if (oTX !== exp) begin
        bad++;
        $display("[TB] FAIL single_tx cycle %0d: got %b expected %b", j, oTX, exp);
      end
      if (j == 0 || j == FRAME_CYC - 1) begin
        total++;
        if (oBUSY !== 1'b1 || oLEVEL !== 3'd0) begin
          bad++;
          $display("[TB] FAIL single_busy cycle %0d: busy=%b level=%0d expected busy=1 level=0", j, oBUSY, oLEVEL);
        end
      end
    end
    @(posedge iCLK);
    #1;
    total++;
    if (oBUSY !== 1'b0 || oTX !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_end: busy=%b tx=%b expected busy=0 tx=1", oBUSY, oTX);
    end
  endtask

  // 0xA3 then 0x0F on consecutive cycles: two contiguous frames with no idle gap.
  task automatic test_back_to_back();
    logic       exp;
    logic [7:0] b;
    iDATA  = 8'hA3;
    iVALID = 1'b1;
    @(posedge iCLK);
    #1;
    iDATA = 8'h0F;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    for (int j = 0; j < 2 * FRAME_CYC; j++) begin
      if (j > 0) begin
        @(posedge iCLK);
        #1;
      end
      b   = (j < FRAME_CYC) ? 8'hA3 : 8'h0F;
      exp = expBit(b, (j % FRAME_CYC) / CLK_DIV);
      total++;
      if (oTX !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_tx cycle %0d: got %b expected %b", j, oTX, exp);
      end
      if (j == FRAME_CYC) begin
        total++;
        if (oBUSY !== 1'b1) begin
          bad++;
          $display("[TB] FAIL b2b_busy_gap: got %b expected 1", oBUSY);
        end
      end
    end
    @(posedge iCLK);
    #1;
    total++;
    if (oBUSY !== 1'b0 || oTX !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_end: busy=%b tx=%b expected busy=0 tx=1", oBUSY, oTX);
    end
  endtask

  // Six bytes 0x01..0x06 offered continuously: FIFO fills, sixth byte stalls
  // until the first frame completes, all six frames leave in order.
  task automatic test_fifo_full();
    int         idx;
    logic       pushNow;
    logic       exp;
    logic [7:0] b;
    idx    = 0;
    iDATA  = 8'h01;
    iVALID = 1'b1;
    for (int c = 0; c <= 6 * FRAME_CYC; c++) begin
      pushNow = iVALID && oREADY;
      @(posedge iCLK);
      #1;
      if (pushNow) begin
        idx++;
        if (idx == 6) iVALID = 1'b0;
        else          iDATA  = 8'(idx + 1);
      end
      if (c >= 1) begin
        b   = 8'((c - 1) / FRAME_CYC + 1);
        exp = expBit(b, ((c - 1) % FRAME_CYC) / CLK_DIV);
        total++;
        if (oTX !== exp) begin
          bad++;
          $display("[TB] FAIL full_tx cycle %0d: got %b expected %b", c, oTX, exp);
        end
      end
      if (c == 4 || c == FRAME_CYC) begin
        total++;
        if (oLEVEL !== 3'd4 || oREADY !== 1'b0) begin
          bad++;
          $display("[TB] FAIL full_level cycle %0d: level=%0d ready=%b expected level=4 ready=0", c, oLEVEL, oREADY);
        end
      end
      if (c == FRAME_CYC + 1) begin
        total++;
        if (oLEVEL !== 3'd3 || oREADY !== 1'b1) begin
          bad++;
          $display("[TB] FAIL full_first_pop: level=%0d ready=%b expected level=3 ready=1", oLEVEL, oREADY);
        end
      end
      if (c == FRAME_CYC + 2) begin
        total++;
        if (oLEVEL !== 3'd4 || idx != 6) begin
          bad++;
          $display("[TB] FAIL full_sixth_push: level=%0d pushed=%0d expected level=4 pushed=6", oLEVEL, idx);
        end
      end
    end
    @(posedge iCLK);
    #1;
    total++;
    if (oBUSY !== 1'b0 || oLEVEL !== 3'd0 || idx != 6) begin
      bad++;
      $display("[TB] FAIL full_end: busy=%b level=%0d pushed=%0d expected busy=0 level=0 pushed=6", oBUSY, oLEVEL, idx);
    end
  endtask

  // Reset pulse in the middle of data bit 3 of 0x11 with 0x22 and 0x33 still queued.
  task automatic test_reset_midframe();
    iDATA  = 8'h11;
    iVALID = 1'b1;
    @(posedge iCLK);
    #1;
    iDATA = 8'h22;
    @(posedge iCLK);
    #1;
    iDATA = 8'h33;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    repeat (16) @(posedge iCLK);
    #1;
    total++;
    if (oTX !== 1'b0 || oLEVEL !== 3'd2) begin
      bad++;
      $display("[TB] FAIL mid_before: tx=%b level=%0d expected tx=0 level=2", oTX, oLEVEL);
    end
    iRST = 1'b1;
    #1;
    total++;
    if (oTX !== 1'b1 || oLEVEL !== 3'd0 || oBUSY !== 1'b0 || oREADY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_async: tx=%b level=%0d busy=%b ready=%b expected tx=1 level=0 busy=0 ready=1",
               oTX, oLEVEL, oBUSY, oREADY);
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    for (int c = 0; c < 3 * FRAME_CYC; c++) begin
      @(posedge iCLK);
      #1;
      total++;
      if (oTX !== 1'b1 || oBUSY !== 1'b0 || oLEVEL !== 3'd0) begin
        bad++;
        $display("[TB] FAIL mid_after cycle %0d: tx=%b busy=%b level=%0d expected tx=1 busy=0 level=0",
                 c, oTX, oBUSY, oLEVEL);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  // 0x07 has three set bits, so the even-parity slot carries 1; frame is 44 cycles.
  task automatic test_parity();
    logic exp;
    iDATA  = 8'h07;
    iVALID = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    for (int j = 0; j < 44; j++) begin
      @(posedge iCLK);
      #1;
      if (j / 4 == 9) exp = 1'b1;
      else            exp = expBit(8'h07, j / 4);
      total++;
      if (oTX !== exp) begin
        bad++;
        $display("[TB] FAIL parity_tx cycle %0d: got %b expected %b", j, oTX, exp);
      end
    end
    @(posedge iCLK);
    #1;
    total++;
    if (oBUSY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL parity_end: busy=%b expected 0", oBUSY);
    end
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    total  = 0;
    bad    = 0;
    iRST   = 1'b1;
    iVALID = 1'b0;
    iDATA  = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
